hazard_stall_ctrl: RTL and testbench

//  Pipeline hazard/stall controller for the 5-stage pipe CPU: the producer side of the PC

---
 rtl/hazard_stall_ctrl.sv | 129 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline hazard/stall controller for the 5-stage CPU.
// Resolves load-use stalls, taken-branch flushes and multi-cycle MDU freezes.
// Also keeps a saturating count of cycles in which the PC was held.
module hazard_stall_ctrl #(
  parameter int REG_W   = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] ifid_rs_i,
  input  logic [REG_W-1:0] ifid_rt_i,
  input  logic             ifid_uses_rt_i,
  input  logic             idex_memread_i,
  input  logic [REG_W-1:0] idex_rt_i,
  input  logic             branch_taken_i,
  input  logic             mdu_start_i,
  input  logic             stat_clr_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_write_o,
  output logic             idex_flush_o,
  output logic             exmem_flush_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  // Remaining-BUSY counter only has to reach MDU_LAT-3.
  localparam int MC_W = (MDU_LAT > 3) ? $clog2(MDU_LAT - 2) : 1;
  localparam logic [MC_W-1:0] MC_INIT = (MDU_LAT >= 3) ? MC_W'(MDU_LAT - 3) : '0;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e           r_state;
  logic [MC_W-1:0]  r_mdu_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_branch;
  logic w_mdu_go;
  logic w_freeze;
  logic w_hazard;
  logic w_lu;

  // Event decode; BUSY ignores branches, RELEASE ignores the still-present MDU op.
  assign w_branch = branch_taken_i & (r_state != BUSY);
  assign w_mdu_go = (r_state == RUN) & mdu_start_i;
  assign w_freeze = (r_state == BUSY) | w_mdu_go;
  assign w_hazard = idex_memread_i & (idex_rt_i != '0) &
                    ((idex_rt_i == ifid_rs_i) | (ifid_uses_rt_i & (idex_rt_i == ifid_rt_i)));
  assign w_lu     = w_hazard & (r_state != BUSY);

  // Same-cycle control outputs, priority branch > MDU > load-use; reset forces bubbles.
  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_write_o  = 1'b1;
    idex_flush_o  = 1'b0;
    exmem_flush_o = 1'b0;
    if (!rst_i) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_write_o  = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_flush_o  = 1'b1;
      exmem_flush_o = 1'b1;
    end else if (w_branch) begin
      ifid_flush_o  = 1'b1;
      idex_flush_o  = 1'b1;
      exmem_flush_o = 1'b1;
    end else if (w_freeze) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_write_o  = 1'b0;
      exmem_flush_o = 1'b1;
    end else if (w_lu) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_flush_o  = 1'b1;
    end
  end

  // MDU sequencing: RUN freezes on start, BUSY counts down, RELEASE lets the op leave EX.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= RUN;
      r_mdu_cnt <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_branch) begin
            r_state <= RUN;
          end else if (mdu_start_i) begin
            if (MDU_LAT == 2) begin
              r_state <= RELEASE;
            end else begin
              r_state   <= BUSY;
              r_mdu_cnt <= MC_INIT;
            end
          end
        end
        BUSY: begin
          if (r_mdu_cnt == '0) r_state <= RELEASE;
          else                 r_mdu_cnt <= r_mdu_cnt - 1'b1;
        end
        RELEASE: r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end

  // Saturating stall-cycle counter; clear wins over increment.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= '0;
    end else if (stat_clr_i) begin
      r_stall_cnt <= '0;
    end else if (!pc_write_o && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two instances (MDU_LAT=4/CNT_W=16 and MDU_LAT=2/CNT_W=3)
// share stimulus and are compared against a cycle-level behavioural model.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rs, rt, ex_rt;
  logic       uses_rt, memread, br, mdu, clr;

  logic [5:0]  ctl [2];
  logic [15:0] cnt0;
  logic [2:0]  cnt1;

  int n_chk = 0;
  int n_bad = 0;

  // model state per instance
  int lat  [2] = '{4, 2};
  int cmax [2] = '{65535, 7};
  int frz  [2];
  bit rel  [2];
  int mcnt [2];

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.REG_W(5), .MDU_LAT(4), .CNT_W(16)) u_d4 (
    .clk_i(clk), .rst_i(rst_n), .ifid_rs_i(rs), .ifid_rt_i(rt), .ifid_uses_rt_i(uses_rt),
    .idex_memread_i(memread), .idex_rt_i(ex_rt), .branch_taken_i(br), .mdu_start_i(mdu),
    .stat_clr_i(clr), .pc_write_o(ctl[0][5]), .ifid_write_o(ctl[0][4]),
    .ifid_flush_o(ctl[0][3]), .idex_write_o(ctl[0][2]), .idex_flush_o(ctl[0][1]),
    .exmem_flush_o(ctl[0][0]), .stall_cnt_o(cnt0));

  hazard_stall_ctrl #(.REG_W(5), .MDU_LAT(2), .CNT_W(3)) u_d2 (
    .clk_i(clk), .rst_i(rst_n), .ifid_rs_i(rs), .ifid_rt_i(rt), .ifid_uses_rt_i(uses_rt),
    .idex_memread_i(memread), .idex_rt_i(ex_rt), .branch_taken_i(br), .mdu_start_i(mdu),
    .stat_clr_i(clr), .pc_write_o(ctl[1][5]), .ifid_write_o(ctl[1][4]),
    .ifid_flush_o(ctl[1][3]), .idex_write_o(ctl[1][2]), .idex_flush_o(ctl[1][1]),
    .exmem_flush_o(ctl[1][0]), .stall_cnt_o(cnt1));

  // control vector order: {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_flush}
  localparam logic [5:0] C_DEF = 6'b110100;
  localparam logic [5:0] C_BR  = 6'b111111;
  localparam logic [5:0] C_FRZ = 6'b000001;
  localparam logic [5:0] C_LU  = 6'b000110;
  localparam logic [5:0] C_RST = 6'b001011;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_cnt(input int m);
    return (m == 0) ? 32'(cnt0) : 32'(cnt1);
  endfunction

  task automatic set_in(input logic mr, input logic [4:0] xr, input logic [4:0] s,
                        input logic [4:0] t, input logic ut, input logic b,
                        input logic md, input logic c);
    memread = mr; ex_rt = xr; rs = s; rt = t; uses_rt = ut; br = b; mdu = md; clr = c;
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      frz[m] = 0; rel[m] = 1'b0; mcnt[m] = 0;
    end
  endtask

  // one clock: check outputs mid-cycle against the model, then advance the model
  task automatic step();
    logic [5:0] e;
    bit hz, busy, nrel;
    @(negedge clk);
    hz = memread && ex_rt != 0 && (ex_rt == rs || (uses_rt && ex_rt == rt));
    for (int m = 0; m < 2; m++) begin
      busy = frz[m] > 0;
      nrel = 1'b0;
      if (!busy && br) begin
        e = C_BR;
      end else if (busy) begin
        e = C_FRZ;
        frz[m]--;
        if (frz[m] == 0) nrel = 1'b1;
      end else if (!rel[m] && mdu) begin
        e = C_FRZ;
        frz[m] = lat[m] - 2;
        if (frz[m] == 0) nrel = 1'b1;
      end else if (hz) begin
        e = C_LU;
      end else begin
        e = C_DEF;
      end
      chk($sformatf("ctl%0d", m), 32'(ctl[m]), 32'(e));
      chk($sformatf("cnt%0d", m), dut_cnt(m), 32'(mcnt[m]));
      if (clr) mcnt[m] = 0;
      else if (!e[5] && mcnt[m] < cmax[m]) mcnt[m]++;
      rel[m] = nrel;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_ctl0", 32'(ctl[0]), 32'(C_RST));
    chk("rst_ctl1", 32'(ctl[1]), 32'(C_RST));
    chk("rst_cnt0", dut_cnt(0), 0);
    chk("rst_cnt1", dut_cnt(1), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    do_reset();

    // T1: load-use on rs, one stall cycle
    set_in(1, 8, 8, 3, 0, 0, 0, 0);
    step();
    set_in(0, 8, 8, 3, 0, 0, 0, 0);
    step();
    chk("t1_cnt", dut_cnt(0), 1);

    // T2: rt match without uses_rt, and register 0
    set_in(1, 8, 2, 8, 0, 0, 0, 0);
    step();
    set_in(1, 0, 0, 0, 1, 0, 0, 0);
    step();

    // T3: branch beats load-use, counter unchanged
    set_in(1, 8, 8, 3, 0, 1, 0, 0);
    step();
    chk("t3_cnt", dut_cnt(0), 1);

    // T4: MDU op held 4 cycles
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 1, 0);
      step();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("t4_cnt", dut_cnt(0), 4);

    // T5: reset in the second BUSY cycle
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    step();
    step();
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("t5_cnt", dut_cnt(0), 0);

    // T6: saturate the 3-bit counter, then clear
    for (int i = 0; i < 9; i++) begin
      set_in(1, 5, 5, 0, 0, 0, 0, 0);
      step();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("t6_sat", dut_cnt(1), 7);
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("t6_clr", dut_cnt(1), 0);

    // random traffic with small register indices to force collisions
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end
      set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 39) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
